// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/accumulate unit.
interface hilo_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output Start, Op, A, B, input Busy, Done, HI, LO);
  modport slave  (input Start, Op, A, B, output Busy, Done, HI, LO);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2^BITS_PER_CYCLE multiply/accumulate owning the MIPS HI/LO pair.
// Optional HILO_EARLY_TERM_EN: finish as soon as the remaining multiplier is zero.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input logic               Clk,
  input logic               Rst,
  hilo_muldiv_unit_if.slave bus
);

  localparam int unsigned W2     = 2 * WIDTH;
  localparam int unsigned NSTEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW     = $clog2(NSTEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W2-1:0]    r_mcand;
  logic [W2-1:0]    r_prod;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_sign;
  logic [1:0]       r_cls;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic                      w_accept;
  logic                      w_mt_wr;
  logic                      w_fin;
  logic                      w_mul_op;
  logic                      w_signed_op;
  logic [WIDTH-1:0]          w_mag_a;
  logic [WIDTH-1:0]          w_mag_b;
  logic [BITS_PER_CYCLE-1:0] w_digit;
  logic [W2-1:0]             w_partial;
  logic [WIDTH-1:0]          w_mplier_shr;
  logic [W2-1:0]             w_prod_fin;
  logic [W2-1:0]             w_acc;
  logic [W2-1:0]             w_res;

  // Op decode: 0..5 multiply class, even codes among those are signed.
  assign w_mul_op    = !(bus.Op[2] && bus.Op[1]);
  assign w_signed_op = w_mul_op && !bus.Op[0];
  assign w_mag_a     = (w_signed_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign w_mag_b     = (w_signed_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  assign w_digit      = r_mplier[BITS_PER_CYCLE-1:0];
  assign w_partial    = r_mcand * W2'(w_digit);
  assign w_mplier_shr = r_mplier >> BITS_PER_CYCLE;

  // Sign restore and accumulate, modulo 2^(2*WIDTH).
  assign w_prod_fin = r_sign ? -r_prod : r_prod;
  assign w_acc      = {r_hi, r_lo};
  always_comb begin
    w_res = w_prod_fin;
    case (r_cls)
      2'b01:   w_res = w_acc + w_prod_fin;
      2'b10:   w_res = w_acc - w_prod_fin;
      default: w_res = w_prod_fin;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mt_wr     = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          if (w_mul_op) begin
            w_accept    = 1'b1;
            w_state_nxt = S_MUL;
          end else begin
            w_mt_wr = 1'b1;
          end
        end
      end
      S_MUL: begin
`ifdef HILO_EARLY_TERM_EN
        if ((r_cnt == CW'(1)) || (w_mplier_shr == '0)) w_state_nxt = S_FIN;
`else
        if (r_cnt == CW'(1)) w_state_nxt = S_FIN;
`endif
      end
      S_FIN: begin
        w_fin       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_cls    <= 2'b00;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fin || w_mt_wr;
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_mcand  <= W2'(w_mag_a);
        r_mplier <= w_mag_b;
        r_prod   <= '0;
        r_cnt    <= CW'(NSTEPS);
        r_sign   <= w_signed_op && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        r_cls    <= bus.Op[2:1];
      end
      if (r_state == S_MUL) begin
        r_prod   <= r_prod + w_partial;
        r_mcand  <= r_mcand << BITS_PER_CYCLE;
        r_mplier <= w_mplier_shr;
        r_cnt    <= r_cnt - CW'(1);
      end
      if (w_fin) {r_hi, r_lo} <= w_res;
      if (w_mt_wr) begin
        if (bus.Op[0]) r_lo <= bus.A;
        else           r_hi <= bus.A;
      end
    end
  end

  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit (WIDTH=32, BITS_PER_CYCLE=4), directed vectors.
module tb_hilo_muldiv_unit;

  localparam bit ET = `ifdef HILO_EARLY_TERM_EN 1'b1 `else 1'b0 `endif;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  logic Clk;
  logic Rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t q[$];
  exp_t m_e;

  hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

  hilo_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every Done pulse retires the oldest expected result.
  always @(negedge Clk) begin
    if (Rst && bus.Done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        m_e = q.pop_front();
        chk({m_e.name, "_hi"}, bus.HI, m_e.hi);
        chk({m_e.name, "_lo"}, bus.LO, m_e.lo);
        chk({m_e.name, "_done_cycle"}, 32'(cyc), 32'(m_e.cyc));
      end
    end
  end

  // Call at a negedge with Busy=0; returns at the negedge after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat_et,
                       input string nm);
    exp_t e;
    int   lat;
    lat = ET ? lat_et : 9;
    if (op >= 3'd6) lat = 0;
    e.hi = eh; e.lo = el; e.cyc = cyc + 1 + lat; e.name = nm;
    q.push_back(e);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(negedge Clk);
    bus.Start = 1'b0;
    chk({nm, "_busy"}, 32'(bus.Busy), (op < 3'd6) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.Busy && n < 60) begin
      @(negedge Clk);
      n++;
    end
    if (bus.Busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    n_vec = 0; n_err = 0;
    Rst = 1'b0;
    bus.Start = 1'b0; bus.Op = 3'd0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge Clk);
    chk("rst_hi", bus.HI, 32'h0);
    chk("rst_lo", bus.LO, 32'h0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    Rst = 1'b1;
    @(negedge Clk);

    issue(3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 2, "mult_m3x5");
    wait_idle();

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 9, "multu_max");
    @(negedge Clk);
    bus.Start = 1'b1; bus.Op = 3'd6; bus.A = 32'h1234;
    @(negedge Clk);
    bus.Start = 1'b0;
    chk("busy_ignore_hi", bus.HI, 32'hFFFFFFFF);
    chk("busy_ignore_lo", bus.LO, 32'hFFFFFFF1);
    wait_idle();

    issue(3'd6, 32'h0, 32'h0, 32'h0, 32'h1, 0, "mthi_0");
    issue(3'd7, 32'd10, 32'h0, 32'h0, 32'd10, 0, "mtlo_10");
    issue(3'd2, 32'd2, 32'd3, 32'h0, 32'd16, 2, "madd_2x3");
    wait_idle();
    issue(3'd5, 32'd1, 32'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, "msubu_wrap");
    wait_idle();
    issue(3'd4, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 2, "msub_neg");
    wait_idle();
    issue(3'd3, 32'h00010000, 32'h00010000, 32'h0, 32'hFFFFFFF9, 6, "maddu_carry");
    wait_idle();
    issue(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 9, "mult_minsq");
    wait_idle();
    issue(3'd0, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 2, "mult_min_x1");
    wait_idle();
    issue(3'd1, 32'd12345, 32'd0, 32'h0, 32'h0, 2, "multu_zero");
    wait_idle();
    issue(3'd0, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 2, "mult_7xm1");
    wait_idle();

    repeat (3) @(negedge Clk);
    chk("idle_done", 32'(bus.Done), 32'd0);
    chk("idle_hi", bus.HI, 32'hFFFFFFFF);
    chk("idle_lo", bus.LO, 32'hFFFFFFF9);

    issue(3'd0, 32'd100, 32'd100, 32'h0, 32'd10000, 3, "mult_aborted");
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    void'(q.pop_back());
    chk("midrst_hi", bus.HI, 32'h0);
    chk("midrst_lo", bus.LO, 32'h0);
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_done", 32'(bus.Done), 32'd0);
    Rst = 1'b1;
    @(negedge Clk);

    issue(3'd1, 32'd6, 32'd7, 32'h0, 32'd42, 2, "multu_6x7");
    wait_idle();
    issue(3'd1, 32'd7, 32'd3, 32'h0, 32'd21, 2, "multu_7x3");
    wait_idle();

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (q.size() != 0) chk("scoreboard_drain", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
